// File: rtl/llr_fetch_ctrl.sv
// LLR fetch controller: drives the address generator, reads LLR memory
// and buffers returned words for the node processor.
module llr_fetch_ctrl #(
    parameter int ADDR_BITS  = 8,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] length,
    output logic                 busy,
    output logic                 done,
    output logic                 ag_reset,
    output logic                 ag_enable,
    input  logic [ADDR_BITS-1:0] ag_address,
    output logic                 mem_rd_en,
    output logic [ADDR_BITS-1:0] mem_rd_addr,
    input  logic [DATA_BITS-1:0] mem_rd_data,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        FETCH,
        DRAIN
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ADDR_BITS-1:0] len_q;
    logic [ADDR_BITS:0]   issued;
    logic                 inflight;
    logic                 done_nxt;
    logic                 issue;
    logic                 push;
    logic                 pop;
    logic                 credit_ok;
    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_nxt;

    // A read only goes out when the buffer can absorb it, counting the
    // word still on its way back from memory.
    assign credit_ok   = (count + CW'(inflight)) < CW'(FIFO_DEPTH);
    assign issue       = (state == FETCH) && (issued < {1'b0, len_q}) && credit_ok;
    assign ag_enable   = issue;
    assign mem_rd_en   = issue;
    assign mem_rd_addr = issue ? ag_address : '0;
    assign busy        = (state != IDLE);

    assign push      = inflight;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;

    // Next-state logic; DRAIN ends once nothing is returning and the
    // buffer empties this cycle.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        ag_reset  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (length != '0) state_nxt = INIT;
                    else done_nxt = 1'b1;
                end
            end
            INIT: begin
                ag_reset  = 1'b1;
                state_nxt = FETCH;
            end
            FETCH: begin
                if (issue && (issued + 1'b1 == {1'b0, len_q}))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!inflight && count_nxt == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state, burst bookkeeping and read-return tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            len_q    <= '0;
            issued   <= '0;
            inflight <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            done     <= done_nxt;
            if (state == IDLE && start && length != '0) begin
                len_q  <= length;
                issued <= '0;
            end else if (issue) begin
                issued <= issued + 1'b1;
            end
        end
    end

    // Buffer pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    // Buffer storage; captures the memory word returning this cycle.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem_rd_data;
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (reset)
        !(push && count == CW'(FIFO_DEPTH))
    );

endmodule

// File: tb/tb_llr_fetch_ctrl.sv
// Bench for llr_fetch_ctrl with a behavioural address generator
// and a synchronous LLR memory returning mem[a] = a + 0x10.
module tb_llr_fetch_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] length = '0;
    logic       busy, done, ag_reset, ag_enable, mem_rd_en, out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] ag_address, mem_rd_addr, mem_rd_data, out_data;

    int n_chk = 0;
    int n_err = 0;
    int n_rd = 0;
    int n_pop = 0;
    int n_done = 0;
    int max_out = 0;
    logic [7:0] got[$];

    typedef struct {
        logic       st;
        logic [7:0] len;
        logic       rdy;
        logic       busy;
        logic       done;
        logic       agr;
        logic       age;
        logic       rde;
        logic [7:0] rda;
        logic       ov;
        logic [7:0] od;
    } vec_t;

    vec_t tbl[14];

    llr_fetch_ctrl #(.ADDR_BITS(8), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .length(length),
        .busy(busy), .done(done), .ag_reset(ag_reset),
        .ag_enable(ag_enable), .ag_address(ag_address),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Address generator model, COUNT_FROM = 0.
    always @(posedge clk or posedge reset) begin
        if (reset) ag_address <= '0;
        else if (ag_reset) ag_address <= '0;
        else if (ag_enable) ag_address <= ag_address + 8'd1;
    end

    // Synchronous memory model.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_rd_addr + 8'h10;
    end

    // Event monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_rd_en) n_rd++;
        if (out_valid && out_ready) begin
            n_pop++;
            got.push_back(out_data);
        end
        if (done) n_done++;
        if (n_rd - n_pop > max_out) max_out = n_rd - n_pop;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        n_rd = 0;
        n_pop = 0;
        n_done = 0;
        max_out = 0;
        got.delete();
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] len);
        cyc();
        start = 1'b1;
        length = len;
        cyc();
        start = 1'b0;
    endtask

    // Run until done is seen (or budget expires), then a few idle cycles.
    task automatic run_done(input int budget, input bit toggle);
        bit seen = 0;
        bit stall = 0;
        logic [7:0] pd = '0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (toggle) out_ready = ~out_ready;
            @(negedge clk);
            if (toggle && stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(pd));
            end
            stall = out_valid && !out_ready;
            pd = out_data;
            seen = done;
            cyc();
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        out_ready = 1'b1;
        repeat (4) cyc();
    endtask

    task automatic chk_words(input string name, input int n);
        chk({name, "_count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++)
            chk({name, "_word"}, 32'(got[i]), 32'(8'h10 + 8'(i)));
    endtask

    function automatic logic [20:0] pack_act(input vec_t v);
        return {busy, done, ag_reset, ag_enable, mem_rd_en,
                v.rde ? mem_rd_addr : 8'h00, out_valid,
                v.ov ? out_data : 8'h00};
    endfunction

    function automatic logic [20:0] pack_exp(input vec_t v);
        return {v.busy, v.done, v.agr, v.age, v.rde, v.rda, v.ov, v.od};
    endfunction

    initial begin
        //           st len    rdy busy dn agr age rde rda    ov od
        tbl[0]  = '{1, 8'd4, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00};
        tbl[1]  = '{0, 8'd4, 1, 1, 0, 1, 0, 0, 8'h00, 0, 8'h00};
        tbl[2]  = '{0, 8'd4, 1, 1, 0, 0, 1, 1, 8'h00, 0, 8'h00};
        tbl[3]  = '{0, 8'd4, 1, 1, 0, 0, 1, 1, 8'h01, 0, 8'h00};
        tbl[4]  = '{0, 8'd4, 1, 1, 0, 0, 1, 1, 8'h02, 1, 8'h10};
        tbl[5]  = '{0, 8'd4, 1, 1, 0, 0, 1, 1, 8'h03, 1, 8'h11};
        tbl[6]  = '{0, 8'd4, 1, 1, 0, 0, 0, 0, 8'h00, 1, 8'h12};
        tbl[7]  = '{0, 8'd4, 1, 1, 0, 0, 0, 0, 8'h00, 1, 8'h13};
        tbl[8]  = '{0, 8'd4, 1, 0, 1, 0, 0, 0, 8'h00, 0, 8'h00};
        tbl[9]  = '{0, 8'd4, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00};
        tbl[10] = '{1, 8'd0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00};
        tbl[11] = '{0, 8'd0, 1, 0, 1, 0, 0, 0, 8'h00, 0, 8'h00};
        tbl[12] = '{0, 8'd0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00};
        tbl[13] = '{0, 8'd0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            32'({busy, done, ag_reset, ag_enable, mem_rd_en,
                 mem_rd_addr, out_valid, out_data}), 32'd0);
        cyc();
        reset = 1'b0;

        // Basic burst of 4 followed by a zero-length start.
        for (int i = 0; i < 14; i++) begin
            start = tbl[i].st;
            length = tbl[i].len;
            out_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(pack_act(tbl[i])),
                32'(pack_exp(tbl[i])));
            cyc();
        end
        start = 1'b0;

        // Back-pressure: only FIFO_DEPTH reads may be outstanding.
        clear_mon();
        out_ready = 1'b0;
        pulse_start(8'd8);
        repeat (12) cyc();
        @(negedge clk);
        chk("bp_reads", 32'(n_rd), 32'd4);
        chk("bp_ag_enable", 32'(ag_enable), 32'd0);
        chk("bp_ag_address", 32'(ag_address), 32'd4);
        chk("bp_head", 32'(out_data), 32'h10);
        cyc();
        out_ready = 1'b1;
        run_done(40, 1'b0);
        chk_words("bp", 8);
        chk("bp_done_once", 32'(n_done), 32'd1);
        chk("bp_max_out", 32'(max_out <= 4), 32'd1);

        // Alternating ready, length 6.
        clear_mon();
        pulse_start(8'd6);
        run_done(60, 1'b1);
        chk_words("tog", 6);
        chk("tog_max_out", 32'(max_out <= 4), 32'd1);
        chk("tog_done_once", 32'(n_done), 32'd1);

        // Reset in the middle of a burst.
        clear_mon();
        pulse_start(8'd8);
        for (int i = 0; i < 30 && n_pop < 2; i++) cyc();
        chk("rst_two_pops", 32'(n_pop), 32'd2);
        reset = 1'b1;
        #1;
        chk("rst_outputs",
            32'({busy, done, ag_reset, ag_enable, mem_rd_en,
                 mem_rd_addr, out_valid, out_data}), 32'd0);
        cyc();
        cyc();
        reset = 1'b0;
        repeat (2) cyc();
        clear_mon();
        pulse_start(8'd2);
        run_done(30, 1'b0);
        chk_words("post_rst", 2);

        // Start pulses while busy are ignored.
        clear_mon();
        pulse_start(8'd3);
        start = 1'b1;
        length = 8'd5;
        cyc();
        start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        run_done(30, 1'b0);
        chk_words("busy_start", 3);
        chk("busy_start_done", 32'(n_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
